// File: rtl/fft8_input_reorder.sv
// fft8_input_reorder: ping-pong staging buffer ahead of FFT stage 0.
// Collects 8 natural-order samples per bank and drains them as four
// bit-reversed butterfly operand pairs (x0, x1).
// Optional build macro FFT8_REORDER_IFFT_EN adds the ifft_mode port; a frame
// written with ifft_mode = 1 is read with index (8 - bitrev3(j)) mod 8.
module fft8_input_reorder #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
`ifdef FFT8_REORDER_IFFT_EN
    input  logic              ifft_mode,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] x0,
    output logic [DATA_W-1:0] x1,
    output logic              out_sof,
    output logic              out_eof
);

    logic [DATA_W-1:0] mem_q [2][8];

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_cnt_q, wr_cnt_d;
    logic [1:0] rd_pair_q, rd_pair_d;
`ifdef FFT8_REORDER_IFFT_EN
    logic [1:0] mode_q, mode_d;
`endif

    logic       wr_fire;
    logic       rd_fire;
    logic [2:0] br0, br1;
    logic [2:0] idx0, idx1;

    // Handshakes derive only from registered state.
    always_comb begin
        in_ready  = !full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
    end

    // Next-state: write pointer/bank, read pair/bank and full flags.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_pair_d = rd_pair_q;
`ifdef FFT8_REORDER_IFFT_EN
        mode_d    = mode_q;
`endif
        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
`ifdef FFT8_REORDER_IFFT_EN
            if (wr_cnt_q == 3'd0) begin
                mode_d[wr_bank_q] = ifft_mode;
            end
`endif
            if (wr_cnt_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        // Write and read banks always differ when both fire, so both updates apply.
        if (rd_fire) begin
            rd_pair_d = rd_pair_q + 2'd1;
            if (rd_pair_q == 2'd3) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    // Control state register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 3'd0;
            rd_pair_q <= 2'd0;
`ifdef FFT8_REORDER_IFFT_EN
            mode_q    <= 2'b00;
`endif
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_pair_q <= rd_pair_d;
`ifdef FFT8_REORDER_IFFT_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Sample storage; contents are left alone on reset since full flags gate reads.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= in_data;
        end
    end

    // Read addressing and outputs: pair k uses words bitrev3(2k) and bitrev3(2k+1).
    always_comb begin
        br0  = {1'b0, rd_pair_q[0], rd_pair_q[1]};
        br1  = {1'b1, rd_pair_q[0], rd_pair_q[1]};
        idx0 = br0;
        idx1 = br1;
`ifdef FFT8_REORDER_IFFT_EN
        // Time reversal: (8 - i) mod 8 falls out of 3-bit wraparound.
        if (mode_q[rd_bank_q]) begin
            idx0 = 3'd0 - br0;
            idx1 = 3'd0 - br1;
        end
`endif
        x0      = out_valid ? mem_q[rd_bank_q][idx0] : '0;
        x1      = out_valid ? mem_q[rd_bank_q][idx1] : '0;
        out_sof = out_valid && (rd_pair_q == 2'd0);
        out_eof = out_valid && (rd_pair_q == 2'd3);
    end

endmodule

// File: tb/tb_fft8_input_reorder.sv
// Self-checking bench for fft8_input_reorder: a frame-queue reference model
// predicts handshakes and operand pairs every cycle; directed steps add
// explicit pair-order checks. Honours FFT8_REORDER_IFFT_EN when defined.
module tb_fft8_input_reorder;

    localparam int DW = 16;
`ifdef FFT8_REORDER_IFFT_EN
    localparam bit IFFT = 1'b1;
`else
    localparam bit IFFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          ifft_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    logic          out_sof;
    logic          out_eof;

    always #5 clk = ~clk;

    fft8_input_reorder #(.DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef FFT8_REORDER_IFFT_EN
        .ifft_mode (ifft_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .x1        (x1),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

    // Reference model: queue of complete frames, a partial frame, pair index of head frame.
    typedef logic [7:0][DW-1:0] frame_t;
    frame_t          fq[$];
    bit              fmode[$];
    frame_t          part;
    int              part_n;
    bit              part_mode;
    int              pair_k;

    logic [DW-1:0]   src[$];
    logic [2*DW-1:0] got[$];
    int              errors = 0;
    int              checks = 0;

    function automatic int br3(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    function automatic int rd_idx(input int j, input bit m);
        return m ? (8 - br3(j)) % 8 : br3(j);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        fmode.delete();
        part_n = 0;
        pair_k = 0;
    endtask

    // One clock: compare at negedge, advance model across the posedge.
    task automatic tick(output bit wr_fire);
        bit            er, ev, rd_fire, m;
        logic [DW-1:0] e0, e1, d;
        er = fq.size() < 2;
        ev = fq.size() > 0;
        e0 = '0;
        e1 = '0;
        if (ev) begin
            e0 = fq[0][rd_idx(2 * pair_k, fmode[0])];
            e1 = fq[0][rd_idx(2 * pair_k + 1, fmode[0])];
        end
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(ev));
        check("x0", 32'(x0), 32'(e0));
        check("x1", 32'(x1), 32'(e1));
        check("out_sof", 32'(out_sof), 32'(ev && pair_k == 0));
        check("out_eof", 32'(out_eof), 32'(ev && pair_k == 3));
        if (out_valid === 1'b1 && out_ready) got.push_back({x0, x1});
        wr_fire = in_valid && er;
        rd_fire = ev && out_ready;
        d = in_data;
        m = IFFT ? ifft_mode : 1'b0;
        @(posedge clk);
        if (rd_fire) begin
            pair_k++;
            if (pair_k == 4) begin
                pair_k = 0;
                void'(fq.pop_front());
                void'(fmode.pop_front());
            end
        end
        if (wr_fire) begin
            if (part_n == 0) part_mode = m;
            part[part_n] = d;
            part_n++;
            if (part_n == 8) begin
                fq.push_back(part);
                fmode.push_back(part_mode);
                part_n = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // rmode: 0 = ready after 'stall' cycles, 1 = toggle, 2 = random.
    task automatic run(input int max_cyc, input int rmode, input int stall,
                       input bit vrand, input bit until_drained);
        bit fire;
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            done = src.size() == 0 && (!until_drained || (fq.size() == 0 && part_n == 0));
            if (done) break;
            in_valid = src.size() > 0 && (!vrand || $urandom_range(0, 1) == 1);
            if (src.size() > 0) in_data = src[0];
            else in_data = DW'($urandom);
            case (rmode)
                0:       out_ready = (c >= stall);
                1:       out_ready = (c % 2 == 0);
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            tick(fire);
            if (fire) void'(src.pop_front());
        end
        done = src.size() == 0 && (!until_drained || (fq.size() == 0 && part_n == 0));
        check("run_done", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic expect_pairs(input string tag, input int n, input int exp[16]);
        check({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check(tag, got[i], {DW'(exp[2 * i]), DW'(exp[2 * i + 1])});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit fire;
        int e1[16] = '{10, 14, 12, 16, 11, 15, 13, 17, 0, 0, 0, 0, 0, 0, 0, 0};
        int e2[16] = '{0, 4, 2, 6, 1, 5, 3, 7, 100, 104, 102, 106, 101, 105, 103, 107};
        int e5[16] = '{20, 24, 22, 26, 21, 25, 23, 27, 0, 0, 0, 0, 0, 0, 0, 0};
        int e6[16] = '{0, 4, 6, 2, 7, 3, 5, 1, 0, 4, 2, 6, 1, 5, 3, 7};
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ifft_mode = 1'b0;
        part_mode = 1'b0;
        do_reset();
        check("rst_x0", 32'(x0), 32'd0);
        check("rst_x1", 32'(x1), 32'd0);
        check("rst_sof", 32'(out_sof), 32'd0);
        check("rst_eof", 32'(out_eof), 32'd0);

        // Single frame 10..17.
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(DW'(10 + i));
        run(40, 0, 0, 1'b0, 1'b1);
        expect_pairs("frame_10_17", 4, e1);

        // Back-to-back frames.
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(DW'(i));
        for (int i = 0; i < 8; i++) src.push_back(DW'(100 + i));
        run(60, 0, 0, 1'b0, 1'b1);
        expect_pairs("back_to_back", 8, e2);

        // Three frames against a 20-cycle stall.
        got.delete();
        for (int i = 0; i < 24; i++) src.push_back(DW'($urandom));
        run(200, 0, 20, 1'b0, 1'b1);
        check("stall_pairs", 32'(got.size()), 32'd12);

        // Toggling out_ready during drain.
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(DW'($urandom));
        run(60, 1, 0, 1'b0, 1'b1);
        check("toggle_pairs", 32'(got.size()), 32'd4);

        // Reset mid-frame, then mid-drain.
        for (int i = 0; i < 5; i++) src.push_back(DW'(200 + i));
        run(20, 0, 0, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) src.push_back(DW'(50 + i));
        run(20, 0, 0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick(fire);
        tick(fire);
        do_reset();
        check("drain_rst_valid", 32'(out_valid), 32'd0);
        got.delete();
        for (int i = 0; i < 8; i++) src.push_back(DW'(20 + i));
        run(40, 0, 0, 1'b0, 1'b1);
        expect_pairs("after_reset", 4, e5);

        // Random soak.
        for (int i = 0; i < 64; i++) src.push_back(DW'($urandom));
        run(2000, 2, 0, 1'b1, 1'b1);

`ifdef FFT8_REORDER_IFFT_EN
        // IFFT frame followed by an FFT frame.
        got.delete();
        ifft_mode = 1'b1;
        for (int i = 0; i < 8; i++) src.push_back(DW'(i));
        run(20, 0, 0, 1'b0, 1'b0);
        ifft_mode = 1'b0;
        for (int i = 0; i < 8; i++) src.push_back(DW'(i));
        run(60, 0, 0, 1'b0, 1'b1);
        expect_pairs("ifft_then_fft", 8, e6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft8_input_reorder.md
# fft8_input_reorder

Input staging buffer directly upstream of the first radix-2 butterfly stage of the 8-point FFT/IFFT datapath. Accepts one signed 16-bit sample per cycle in natural order, stores full 8-sample frames in a two-bank ping-pong memory, and presents them as four butterfly operand pairs in bit-reversed order (x0/x1 inputs of the stage-0 butterfly). Writing one bank while draining the other gives sustained throughput of one frame per 8 input cycles.

## Interface
- DATA_W, 16, sample width (signed two's complement)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clock clk
- in_valid  input  1  in_data valid this cycle
- in_data  input  DATA_W  sample, natural time order n = 0..7 per frame
- in_ready  output  1  buffer can accept a sample this cycle
- ifft_mode  input  1  (only with FFT8_REORDER_IFFT_EN) frame uses IFFT index order
- out_valid  output  1  x0/x1 hold a valid operand pair
- out_ready  input  1  downstream accepts pair this cycle
- x0  output  DATA_W  first butterfly operand
- x1  output  DATA_W  second butterfly operand
- out_sof  output  1  high with pair 0 of a frame
- out_eof  output  1  high with pair 3 of a frame

## Operation
- Storage: 2 banks × 8 words of DATA_W, registered full[1:0] flags, wr_bank, rd_bank, wr_cnt[2:0], rd_pair[1:0].
- Write: transfer when in_valid && in_ready; word stored at bank[wr_bank][wr_cnt]; wr_cnt increments, wraps 7→0. On the 8th transfer full[wr_bank] sets and wr_bank toggles.
- in_ready = !full[wr_bank] (combinational from registered state).
- Read: out_valid = full[rd_bank]. Pair k (k = rd_pair) is words (bitrev3(2k), bitrev3(2k+1)): (0,4), (2,6), (1,5), (3,7).
- Transfer when out_valid && out_ready; rd_pair increments. On transfer of pair 3: full[rd_bank] clears, rd_bank toggles, rd_pair returns to 0.
- x0/x1 driven 0 when out_valid = 0; stable while out_valid && !out_ready.
- out_sof = out_valid && rd_pair == 0; out_eof = out_valid && rd_pair == 3.
- No arithmetic; data passed bit-exact, no width change.
- Simultaneous fill of one bank and release of the other on the same edge: both take effect; no conflict since banks differ.
- Both banks full: in_ready = 0; in_valid ignored, no data lost or overwritten.
- Reset (any time, including mid-frame or mid-drain): full = 00, wr_bank = rd_bank = 0, wr_cnt = 0, rd_pair = 0; partial frames discarded. Bank contents need not be cleared.

## Timing
- Reset values: in_ready = 1, out_valid = 0, x0 = x1 = 0, out_sof = out_eof = 0.
- Latency: 8th sample accepted at edge N → out_valid = 1 with pair 0 in cycle following edge N.
- Drain: 4 cycles per frame with out_ready held high; pairs on consecutive cycles.
- Bank release: pair 3 transferred at edge M → that bank's in_ready visible from cycle after edge M.
- Sustained throughput: 1 sample/cycle in with continuous out_ready; in_ready never drops.

## Configuration
- FFT8_REORDER_IFFT_EN defined: ifft_mode port exists; sampled with the first word (wr_cnt = 0) of each frame and stored per bank. When the stored bit is 1, the frame is read with index (8 − bitrev3(j)) mod 8, giving pairs (0,4), (6,2), (7,3), (5,1) (time-reversal for IFFT via forward FFT core).
- Undefined: no ifft_mode port, no per-bank mode bit; FFT order always.

## Test plan
- Reset, then samples 10..17 on consecutive cycles, out_ready = 1 → pairs (10,14), (12,16), (11,15), (13,17) on 4 consecutive cycles starting cycle after 8th sample; sof on first, eof on last.
- Two back-to-back frames 0..7 and 100..107, out_ready = 1 → in_ready stays 1 throughout; 8 pairs in order, second frame starts immediately after first eof.
- out_ready = 0 for 20 cycles while 3 frames offered → in_ready drops after 16 samples; pair (0,4) held stable; releasing out_ready drains all 3 frames without loss.
- out_ready toggled 1/0 each cycle during drain → each pair held until accepted; out_eof only with pair 3.
- Assert reset after 5 samples of a frame and again mid-drain → out_valid = 0, in_ready = 1 next cycle; following full frame 20..27 outputs (20,24), (22,26), (21,25), (23,27).
- With FFT8_REORDER_IFFT_EN, ifft_mode = 1 at first word, samples 0..7 → pairs (0,4), (6,2), (7,3), (5,1); next frame with ifft_mode = 0 returns FFT order.
